// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control encodings for the multi-cycle RV32I control unit:
// opcodes, aluop / mux-select encodings, FSM states and instruction-class
// bit positions. The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_JAL  = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_TGT  = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MDR  = 2'b01;
  localparam logic [1:0] M2R_LINK = 2'b10;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Instruction-class one-hot bit positions
  localparam int CLS_R    = 0;
  localparam int CLS_IMM  = 1;
  localparam int CLS_LUI  = 2;
  localparam int CLS_LD   = 3;
  localparam int CLS_ST   = 4;
  localparam int CLS_BR   = 5;
  localparam int CLS_JAL  = 6;
  localparam int CLS_JALR = 7;
  localparam int CLS_SYS  = 8;
  localparam int CLS_ILL  = 9;
  localparam int CLS_W    = 10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
`ifdef ILLEGAL_TRAP_EN
    ,S_TRAP  = 3'd6
`endif
  } state_e;

endpackage

// File: rtl/multicycle_control_fsm_opdec.sv
// Combinational opcode classifier: instr[6:0] -> instruction-class one-hot.
// Anything not recognised lands in the "illegal" class.
module ctrl_opcode_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0]        opcode,
  output logic [CLS_W-1:0]  cls
);

  // One bit per class; exactly one bit is set for any opcode
  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls[CLS_R]    = 1'b1;
      OP_IMM:    cls[CLS_IMM]  = 1'b1;
      OP_LUI:    cls[CLS_LUI]  = 1'b1;
      OP_LOAD:   cls[CLS_LD]   = 1'b1;
      OP_STORE:  cls[CLS_ST]   = 1'b1;
      OP_BRANCH: cls[CLS_BR]   = 1'b1;
      OP_JAL:    cls[CLS_JAL]  = 1'b1;
      OP_JALR:   cls[CLS_JALR] = 1'b1;
      OP_SYSTEM: cls[CLS_SYS]  = 1'b1;
      default:   cls[CLS_ILL]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32I datapath.
// FETCH/DECODE/EXEC/MEM/WB sequencing, memory handshake, retire counter,
// sticky halt on ECALL/EBREAK. Define ILLEGAL_TRAP_EN to trap unknown
// opcodes into a TRAP state (adds the illegal_instr output).
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             i_type,
  output logic             lui_flag,
  output logic             halted,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal_instr,
`endif
  output logic [CNT_W-1:0] instret
);

  state_e             state_q, state_d;
  logic               halted_q;
  logic [CNT_W-1:0]   instret_q;
  logic [CLS_W-1:0]   cls;
  logic               retire;
`ifdef ILLEGAL_TRAP_EN
  logic               illegal_q;
`endif

  ctrl_opcode_decode u_dec (
    .opcode (opcode),
    .cls    (cls)
  );

  // Next state and all strobes; rst forces everything quiet the same cycle
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = M2R_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    aluop         = ALUOP_ADD;
    i_type        = 1'b0;
    lui_flag      = 1'b0;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          // branch/JAL target (PC+imm) goes into the target register
          alu_src_b = SRCB_IMM;
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (cls[CLS_R]) begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_FUNC;
            state_d   = S_WB;
          end else if (cls[CLS_IMM]) begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNC;
            i_type    = 1'b1;
            state_d   = S_WB;
          end else if (cls[CLS_LUI]) begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNC;
            lui_flag  = 1'b1;
            state_d   = S_WB;
          end else if (cls[CLS_LD] || cls[CLS_ST]) begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = S_MEM;
          end else if (cls[CLS_BR]) begin
            alu_src_a     = SRCA_RS1;
            aluop         = ALUOP_BR;
            pc_write_cond = 1'b1;
            pc_src        = PCSRC_TGT;
          end else if (cls[CLS_JAL]) begin
            aluop    = ALUOP_JAL;
            pc_write = 1'b1;
            pc_src   = PCSRC_TGT;
            state_d  = S_WB;
          end else if (cls[CLS_JALR]) begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            pc_write  = 1'b1;
            pc_src    = PCSRC_JALR;
            state_d   = S_WB;
          end else if (cls[CLS_SYS]) begin
            state_d = S_HALT;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;  // unknown opcode retires as a NOP
`endif
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = cls[CLS_LD];
          mem_write = cls[CLS_ST];
          if (mem_ready) state_d = cls[CLS_LD] ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write = 1'b1;
          if (cls[CLS_LD])                     mem_to_reg = M2R_MDR;
          else if (cls[CLS_JAL] || cls[CLS_JALR]) mem_to_reg = M2R_LINK;
          state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  state_d = S_TRAP;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  // An instruction retires when EXEC, MEM or WB hands back to FETCH
  assign retire = !rst && (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  // State, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      instret_q <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_d == S_HALT) halted_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
`ifdef ILLEGAL_TRAP_EN
      if (state_d == S_TRAP) illegal_q <= 1'b1;
`endif
    end
  end

  assign halted  = halted_q;
  assign instret = instret_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm. One record per
// clock: inputs driven at negedge, outputs sampled 1 time unit later.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic        reg_write, i_type, lui_flag, halted;
  logic [1:0]  pc_src, mem_to_reg, alu_src_a, alu_src_b, aluop;
  logic [31:0] instret;
  logic        ill;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .i_type(i_type), .lui_flag(lui_flag), .halted(halted),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(ill),
`endif
    .instret(instret)
  );
`ifndef ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  // control word: pcw pcc pcs[2] irw iod mr mw rw m2r[2] a[2] b[2] aop[2] it lui
  logic [18:0] cw;
  assign cw = {pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read,
               mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop,
               i_type, lui_flag};

  localparam logic [18:0] ZERO    = 19'b0_0_00_0_0_0_0_0_00_00_00_00_0_0;
  localparam logic [18:0] F_WAIT  = 19'b0_0_00_0_0_1_0_0_00_00_01_00_0_0;
  localparam logic [18:0] F_RDY   = 19'b1_0_00_1_0_1_0_0_00_00_01_00_0_0;
  localparam logic [18:0] DEC     = 19'b0_0_00_0_0_0_0_0_00_00_10_00_0_0;
  localparam logic [18:0] EX_R    = 19'b0_0_00_0_0_0_0_0_00_01_00_10_0_0;
  localparam logic [18:0] EX_IMM  = 19'b0_0_00_0_0_0_0_0_00_01_10_10_1_0;
  localparam logic [18:0] EX_LUI  = 19'b0_0_00_0_0_0_0_0_00_10_10_10_0_1;
  localparam logic [18:0] EX_LS   = 19'b0_0_00_0_0_0_0_0_00_01_10_00_0_0;
  localparam logic [18:0] EX_BR   = 19'b0_1_01_0_0_0_0_0_00_01_00_01_0_0;
  localparam logic [18:0] EX_JAL  = 19'b1_0_01_0_0_0_0_0_00_00_00_11_0_0;
  localparam logic [18:0] EX_JALR = 19'b1_0_10_0_0_0_0_0_00_01_10_00_0_0;
  localparam logic [18:0] MEM_LD  = 19'b0_0_00_0_1_1_0_0_00_00_00_00_0_0;
  localparam logic [18:0] MEM_ST  = 19'b0_0_00_0_1_0_1_0_00_00_00_00_0_0;
  localparam logic [18:0] WB_ALU  = 19'b0_0_00_0_0_0_0_1_00_00_00_00_0_0;
  localparam logic [18:0] WB_LD   = 19'b0_0_00_0_0_0_0_1_01_00_00_00_0_0;
  localparam logic [18:0] WB_LNK  = 19'b0_0_00_0_0_0_0_1_10_00_00_00_0_0;

  localparam logic [6:0] R = 7'b0110011, IMM = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, SYS = 7'b1110011;
  localparam logic [6:0] UNK = 7'b0000000;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [18:0] cw;
    logic        halted;
    logic [31:0] instret;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input string n, input logic r, input logic [6:0] op,
                     input logic rdy, input logic [18:0] c, input logic h,
                     input logic [31:0] ir, input logic il);
    vec_t v;
    v.name = n; v.rst = r; v.op = op; v.rdy = rdy; v.cw = c;
    v.halted = h; v.instret = ir; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [18:0] ecw, input logic eh,
                       input logic [31:0] eir, input logic eil);
    logic bad;
    n_vec++;
    bad = (cw !== ecw) || (halted !== eh) || (instret !== eir);
`ifdef ILLEGAL_TRAP_EN
    bad = bad || (ill !== eil);
`endif
    if (bad) begin
      n_err++;
      $display("FAIL %s: cw=%b want %b halted=%b want %b instret=%0d want %0d ill=%b want %b",
               n, cw, ecw, halted, eh, instret, eir, ill, eil);
    end
  endtask

  initial begin
    int cyc;
    bit seen;

    // reset and R-type ADD
    add("rst",      1, R,  0, ZERO,   0, 0, 0);
    add("add.f",    0, R,  1, F_RDY,  0, 0, 0);
    add("add.d",    0, R,  1, DEC,    0, 0, 0);
    add("add.ex",   0, R,  1, EX_R,   0, 0, 0);
    add("add.wb",   0, R,  1, WB_ALU, 0, 0, 0);
    // LW, 2 stalls in FETCH, 3 in MEM: 10 cycles
    add("lw.fw0",   0, LD, 0, F_WAIT, 0, 1, 0);
    add("lw.fw1",   0, LD, 0, F_WAIT, 0, 1, 0);
    add("lw.f",     0, LD, 1, F_RDY,  0, 1, 0);
    add("lw.d",     0, LD, 1, DEC,    0, 1, 0);
    add("lw.ex",    0, LD, 1, EX_LS,  0, 1, 0);
    add("lw.mw0",   0, LD, 0, MEM_LD, 0, 1, 0);
    add("lw.mw1",   0, LD, 0, MEM_LD, 0, 1, 0);
    add("lw.mw2",   0, LD, 0, MEM_LD, 0, 1, 0);
    add("lw.m",     0, LD, 1, MEM_LD, 0, 1, 0);
    add("lw.wb",    0, LD, 1, WB_LD,  0, 1, 0);
    // BEQ: 3 cycles
    add("beq.f",    0, BR, 1, F_RDY,  0, 2, 0);
    add("beq.d",    0, BR, 1, DEC,    0, 2, 0);
    add("beq.ex",   0, BR, 1, EX_BR,  0, 2, 0);
    // LUI then ADDI
    add("lui.f",    0, LUI, 1, F_RDY,  0, 3, 0);
    add("lui.d",    0, LUI, 1, DEC,    0, 3, 0);
    add("lui.ex",   0, LUI, 1, EX_LUI, 0, 3, 0);
    add("lui.wb",   0, LUI, 1, WB_ALU, 0, 3, 0);
    add("addi.f",   0, IMM, 1, F_RDY,  0, 4, 0);
    add("addi.d",   0, IMM, 1, DEC,    0, 4, 0);
    add("addi.ex",  0, IMM, 1, EX_IMM, 0, 4, 0);
    add("addi.wb",  0, IMM, 1, WB_ALU, 0, 4, 0);
    // JAL / JALR
    add("jal.f",    0, JAL, 1, F_RDY,   0, 5, 0);
    add("jal.d",    0, JAL, 1, DEC,     0, 5, 0);
    add("jal.ex",   0, JAL, 1, EX_JAL,  0, 5, 0);
    add("jal.wb",   0, JAL, 1, WB_LNK,  0, 5, 0);
    add("jalr.f",   0, JALR, 1, F_RDY,  0, 6, 0);
    add("jalr.d",   0, JALR, 1, DEC,    0, 6, 0);
    add("jalr.ex",  0, JALR, 1, EX_JALR, 0, 6, 0);
    add("jalr.wb",  0, JALR, 1, WB_LNK, 0, 6, 0);
    // SW with one MEM stall
    add("sw.f",     0, ST, 1, F_RDY,  0, 7, 0);
    add("sw.d",     0, ST, 1, DEC,    0, 7, 0);
    add("sw.ex",    0, ST, 1, EX_LS,  0, 7, 0);
    add("sw.mw",    0, ST, 0, MEM_ST, 0, 7, 0);
    add("sw.m",     0, ST, 1, MEM_ST, 0, 7, 0);
    // SW killed by rst in MEM while mem_ready=1
    add("swr.f",    0, ST, 1, F_RDY,  0, 8, 0);
    add("swr.d",    0, ST, 1, DEC,    0, 8, 0);
    add("swr.ex",   0, ST, 1, EX_LS,  0, 8, 0);
    add("swr.rst",  1, ST, 1, ZERO,   0, 8, 0);
    add("swr.fw",   0, ST, 0, F_WAIT, 0, 0, 0);
    // unknown opcode
    add("unk.f",    0, UNK, 1, F_RDY, 0, 0, 0);
    add("unk.d",    0, UNK, 1, DEC,   0, 0, 0);
    add("unk.ex",   0, UNK, 1, ZERO,  0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) add("unk.trap", 0, UNK, 1, ZERO, 0, 0, 1);
    add("trap.rst", 1, SYS, 1, ZERO,  0, 0, 1);
    add("ecall.f",  0, SYS, 1, F_RDY, 0, 0, 0);
    add("ecall.d",  0, SYS, 1, DEC,   0, 0, 0);
    add("ecall.ex", 0, SYS, 1, ZERO,  0, 0, 0);
    for (int i = 0; i < 20; i++) add("halt", 0, SYS, 1, ZERO, 1, 0, 0);
`else
    add("ecall.f",  0, SYS, 1, F_RDY, 0, 1, 0);
    add("ecall.d",  0, SYS, 1, DEC,   0, 1, 0);
    add("ecall.ex", 0, SYS, 1, ZERO,  0, 1, 0);
    for (int i = 0; i < 20; i++) add("halt", 0, SYS, 1, ZERO, 1, 1, 0);
`endif

    // one unchecked reset edge so registers are defined
    rst = 1'b1; opcode = R; mem_ready = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      #1;
      check(vecs[i].name, vecs[i].cw, vecs[i].halted, vecs[i].instret, vecs[i].ill);
    end

    // hand sequence: leave HALT via rst, ADD must reach WB within budget
    @(negedge clk); rst = 1'b1; opcode = R; mem_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (reg_write === 1'b1) begin seen = 1'b1; cyc = c; end
      else @(negedge clk);
    end
    n_vec++;
    if (!seen || cyc != 3) begin
      n_err++;
      $display("FAIL post_halt_wb: seen=%0d cycle=%0d want seen=1 cycle=3", seen, cyc);
    end
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL post_halt_clear: halted=%b want 0", halted);
    end
    @(negedge clk); #1;
    n_vec++;
    if (instret !== 32'd1 || cw !== F_RDY) begin
      n_err++;
      $display("FAIL post_halt_retire: instret=%0d want 1 cw=%b want %b", instret, cw, F_RDY);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want bench completion");
    $fatal(1, "watchdog");
  end

endmodule
